// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the 16-bit multi-cycle core: sequences fetch/decode/execute/memory/write-back
// and drives every datapath mux select and strobe from the registered state.
`default_nettype none

module multicycle_control_fsm #(
   parameter int ILLEGAL_TRAP = 1,
   parameter int OPC_W        = 4
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [15:0] Instr,
   input  logic        Zero,
   input  logic        MemReady,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [2:0]  WriteRegister,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUCtrl,
   output logic [1:0]  PCSource,
   output logic        Halted,
   output logic [3:0]  State
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC     = 4'd2,
      S_ALU_WB   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_HALT     = 4'd15
   } state_e;

   typedef struct packed {
      logic       mem_read;
      logic       iord;
      logic       mem_write;
      logic       fetch;
      logic       pc_write;
      logic       pc_write_cond;
      logic       reg_write;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluctrl;
      logic [1:0] pcsource;
      logic       halted;
   } ctrl_t;

   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   logic [OPC_W-1:0] opc;
   state_e           state_q, state_d;
   ctrl_t            ctrl_q;
   logic             unused_ok;

   assign opc       = Instr[15 -: OPC_W];
   assign unused_ok = ^{Zero, Instr[8:0]};

   // Moore decode of a state; the opcode only matters for the EXEC operand/ALU selection.
   function automatic ctrl_t decode_ctrl(input state_e s, input logic [OPC_W-1:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read = 1'b1;
            c.fetch    = 1'b1;
            c.alusrcb  = 2'b01;
            c.aluctrl  = ALU_ADD;
         end
         S_EXEC: begin
            c.alusrca = 1'b1;
            if (op == OP_ADDI) begin
               c.alusrcb = 2'b10;
               c.aluctrl = ALU_ADD;
            end else begin
               c.alusrcb = 2'b00;
               c.aluctrl = {1'b0, op[1:0]};
            end
         end
         S_ALU_WB: begin
            c.reg_write = 1'b1;
         end
         S_MEM_ADDR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluctrl = ALU_ADD;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write = 1'b1;
            c.memtoreg  = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca       = 1'b1;
            c.alusrcb       = 2'b00;
            c.aluctrl       = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pcsource      = 2'b01;
         end
         S_JUMP: begin
            c.pc_write = 1'b1;
            c.pcsource = 2'b10;
         end
         S_HALT: begin
            c.halted = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opc)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_d = S_EXEC;
               OP_LW, OP_SW:                           state_d = S_MEM_ADDR;
               OP_BEQ:                                 state_d = S_BRANCH;
               OP_JMP:                                 state_d = S_JUMP;
               default: state_d = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;
            endcase
         end
         S_EXEC:     state_d = S_ALU_WB;
         S_ALU_WB:   state_d = S_FETCH;
         S_MEM_ADDR: state_d = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   state_d = MemReady ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   state_d = S_FETCH;
         S_MEM_WR:   state_d = MemReady ? S_FETCH : S_MEM_WR;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Control bits are registered from the next state so they line up with state_q.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_ctrl(S_FETCH, opc);
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode_ctrl(state_d, opc);
      end
   end

   // Holding reset forces every output low at once, even mid-access.
   assign PCWrite       = Rst_n & (ctrl_q.pc_write | (ctrl_q.fetch & MemReady));
   assign IRWrite       = Rst_n & ctrl_q.fetch & MemReady;
   assign PCWriteCond   = Rst_n & ctrl_q.pc_write_cond;
   assign IorD          = Rst_n & ctrl_q.iord;
   assign MemRead       = Rst_n & ctrl_q.mem_read;
   assign MemWrite      = Rst_n & ctrl_q.mem_write;
   assign RegWrite      = Rst_n & ctrl_q.reg_write;
   assign MemtoReg      = Rst_n & ctrl_q.memtoreg;
   assign ALUSrcA       = Rst_n & ctrl_q.alusrca;
   assign ALUSrcB       = Rst_n ? ctrl_q.alusrcb  : 2'b00;
   assign ALUCtrl       = Rst_n ? ctrl_q.aluctrl  : 3'b000;
   assign PCSource      = Rst_n ? ctrl_q.pcsource : 2'b00;
   assign Halted        = Rst_n & ctrl_q.halted;
   assign WriteRegister = Rst_n ? Instr[11:9] : 3'b000;
   assign State         = Rst_n ? state_q : 4'd0;

endmodule

`default_nettype wire
